// File: rtl/memory_arbiter_if.sv
// CPU instruction/data ports and RAM request/response bundle for memory_arbiter.
// slave: the arbiter's view; master: the CPU/RAM environment driving it.
interface memory_arbiter_if;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    logic        dren;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    logic        ram_req;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, dstore, ram_rdata, ram_ready,
        output iload, iwait, dload, dwait, ram_req, ram_wen, ram_addr, ram_wdata
    );

    modport master (
        output iren, iaddr, dren, dwen, daddr, dstore, ram_rdata, ram_ready,
        input  iload, iwait, dload, dwait, ram_req, ram_wen, ram_addr, ram_wdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) to single-RAM arbiter, one transaction in flight.
// Define MEMORY_ARBITER_IBUF_EN to add a one-entry instruction fetch buffer.
module memory_arbiter (
    input  logic             clk,
    input  logic             rst,
    memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t      state, state_nxt;
    logic        last_d;
    logic [31:0] addr_q;
    logic [3:0]  wen_q;
    logic [31:0] wdata_q;

    logic i_hit, i_pend, d_pend, done, i_ok, d_ok;

`ifdef MEMORY_ARBITER_IBUF_EN
    logic        ibuf_v;
    logic [29:0] ibuf_tag;
    logic [31:0] ibuf_data;

    assign i_hit = (state == IDLE) && bus.iren && ibuf_v && (ibuf_tag == bus.iaddr[31:2]);

    // Fill on every instruction completion; a store to the buffered word kills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_v    <= 1'b0;
            ibuf_tag  <= '0;
            ibuf_data <= '0;
        end else if (done && state == IBUSY) begin
            ibuf_v    <= 1'b1;
            ibuf_tag  <= addr_q[31:2];
            ibuf_data <= bus.ram_rdata;
        end else if (done && state == DBUSY && wen_q != 4'b0 && addr_q[31:2] == ibuf_tag) begin
            ibuf_v    <= 1'b0;
        end
    end
`else
    assign i_hit = 1'b0;
`endif

    assign i_pend = bus.iren && !i_hit;
    assign d_pend = bus.dren || (bus.dwen != 4'b0);
    assign done   = (state != IDLE) && bus.ram_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // Data wins a tie unless data was the last completed grant.
                if (d_pend && (!i_pend || !last_d)) state_nxt = DBUSY;
                else if (i_pend)                    state_nxt = IBUSY;
            end
            IBUSY, DBUSY: if (bus.ram_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (done) last_d <= (state == DBUSY);
            if (state == IDLE && state_nxt == DBUSY) begin
                addr_q  <= {bus.daddr[31:2], 2'b00};
                wen_q   <= bus.dwen;
                wdata_q <= bus.dstore;
            end else if (state == IDLE && state_nxt == IBUSY) begin
                addr_q  <= {bus.iaddr[31:2], 2'b00};
                wen_q   <= 4'b0;
                wdata_q <= '0;
            end
        end
    end

    // A redirected fetch (iaddr moved during IBUSY) completes silently and is dropped.
    assign d_ok = !rst && (state == DBUSY) && bus.ram_ready;
    assign i_ok = !rst && (i_hit || ((state == IBUSY) && bus.ram_ready && bus.iren &&
                                     (bus.iaddr[31:2] == addr_q[31:2])));

    always_comb begin
        bus.ram_req   = !rst && (state != IDLE);
        bus.ram_wen   = bus.ram_req ? wen_q : 4'b0;
        bus.ram_addr  = rst ? 32'b0 : addr_q;
        bus.ram_wdata = rst ? 32'b0 : wdata_q;
        bus.dwait     = !d_ok;
        bus.dload     = d_ok ? bus.ram_rdata : 32'b0;
        bus.iwait     = !i_ok;
        bus.iload     = 32'b0;
        if (i_ok) begin
`ifdef MEMORY_ARBITER_IBUF_EN
            bus.iload = i_hit ? ibuf_data : bus.ram_rdata;
`else
            bus.iload = bus.ram_rdata;
`endif
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed test of memory_arbiter: latency, tie-break, stores, redirect, reset.
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    memory_arbiter_if bus ();
    memory_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.iren = 0; bus.iaddr = 0; bus.dren = 0; bus.dwen = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ram_ready = 0; bus.ram_rdata = 0;
    endtask

    initial begin
        idle_in();
        rst = 1;
        tick();
        bus.ram_ready = 1; bus.ram_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_req",   {31'b0, bus.ram_req}, 0);
        chk("rst_wen",   {28'b0, bus.ram_wen}, 0);
        chk("rst_addr",  bus.ram_addr, 0);
        chk("rst_wdata", bus.ram_wdata, 0);
        chk("rst_iwait", {31'b0, bus.iwait}, 1);
        chk("rst_dwait", {31'b0, bus.dwait}, 1);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        tick();
        rst = 0;
        idle_in();

        // Single fetch: 2-cycle latency
        bus.iren = 1; bus.iaddr = 32'h100;
        #1;
        chk("f1_idle_req", {31'b0, bus.ram_req}, 0);
        chk("f1_idle_iwait", {31'b0, bus.iwait}, 1);
        tick();
        bus.ram_ready = 1; bus.ram_rdata = 32'h13;
        #1;
        chk("f1_req",   {31'b0, bus.ram_req}, 1);
        chk("f1_addr",  bus.ram_addr, 32'h100);
        chk("f1_wen",   {28'b0, bus.ram_wen}, 0);
        chk("f1_iwait", {31'b0, bus.iwait}, 0);
        chk("f1_iload", bus.iload, 32'h13);
        tick();
        idle_in();
        #1;
        chk("f1_back_req", {31'b0, bus.ram_req}, 0);

        // Both pending: data first, then instruction
        bus.iren = 1; bus.iaddr = 32'h0; bus.dren = 1; bus.daddr = 32'h204;
        tick();
        bus.ram_ready = 1; bus.ram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("arb_d_addr",  bus.ram_addr, 32'h204);
        chk("arb_d_dwait", {31'b0, bus.dwait}, 0);
        chk("arb_d_dload", bus.dload, 32'hDEAD_BEEF);
        chk("arb_d_iwait", {31'b0, bus.iwait}, 1);
        chk("arb_d_iload", bus.iload, 0);
        tick();
        bus.ram_ready = 0;
        #1;
        chk("arb_gap_req", {31'b0, bus.ram_req}, 0);
        chk("arb_gap_dwait", {31'b0, bus.dwait}, 1);
        tick();
        bus.ram_ready = 1; bus.ram_rdata = 32'h55;
        #1;
        chk("arb_i_addr",  bus.ram_addr, 32'h0);
        chk("arb_i_iwait", {31'b0, bus.iwait}, 0);
        chk("arb_i_iload", bus.iload, 32'h55);
        chk("arb_i_dwait", {31'b0, bus.dwait}, 1);
        tick();
        idle_in();

        // Byte store with RAM stalling 3 cycles
        bus.dwen = 4'b0100; bus.daddr = 32'h302; bus.dstore = 32'h00AB_0000;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.dstore = 32'h1234_5678;
            bus.ram_ready = (k == 3);
            bus.ram_rdata = 32'h0;
            #1;
            chk("st_req",   {31'b0, bus.ram_req}, 1);
            chk("st_addr",  bus.ram_addr, 32'h300);
            chk("st_wen",   {28'b0, bus.ram_wen}, 32'h4);
            chk("st_wdata", bus.ram_wdata, 32'h00AB_0000);
            chk("st_dwait", {31'b0, bus.dwait}, (k == 3) ? 0 : 1);
            tick();
        end
        idle_in();
        #1;
        chk("st_idle_wen", {28'b0, bus.ram_wen}, 0);

        // Redirect during IBUSY drops the stale response
        bus.iren = 1; bus.iaddr = 32'h40;
        tick();
        #1;
        chk("rd_addr40", bus.ram_addr, 32'h40);
        chk("rd_wait0",  {31'b0, bus.iwait}, 1);
        tick();
        bus.iaddr = 32'h80; bus.ram_ready = 1; bus.ram_rdata = 32'h1111;
        #1;
        chk("rd_drop_iwait", {31'b0, bus.iwait}, 1);
        chk("rd_drop_iload", bus.iload, 0);
        tick();
        bus.ram_ready = 0;
        #1;
        chk("rd_idle_req", {31'b0, bus.ram_req}, 0);
        tick();
        bus.ram_ready = 1; bus.ram_rdata = 32'h2222;
        #1;
        chk("rd_addr80", bus.ram_addr, 32'h80);
        chk("rd_iwait",  {31'b0, bus.iwait}, 0);
        chk("rd_iload",  bus.iload, 32'h2222);
        tick();
        idle_in();

        // Reset mid-DBUSY with ram_ready in the same cycle
        bus.dren = 1; bus.daddr = 32'h10;
        tick();
        rst = 1; bus.ram_ready = 1; bus.ram_rdata = 32'hAAAA;
        #1;
        chk("mrst_dwait", {31'b0, bus.dwait}, 1);
        chk("mrst_dload", bus.dload, 0);
        chk("mrst_req",   {31'b0, bus.ram_req}, 0);
        tick();
        rst = 0; bus.dren = 0;
        #1;
        chk("mrst_idle_req",  {31'b0, bus.ram_req}, 0);
        chk("mrst_idle_addr", bus.ram_addr, 0);
        chk("mrst_idle_dwait", {31'b0, bus.dwait}, 1);
        tick();
        #1;
        chk("stray_ready_req", {31'b0, bus.ram_req}, 0);
        tick();
        idle_in();

`ifdef MEMORY_ARBITER_IBUF_EN
        bus.iren = 1; bus.iaddr = 32'h10;
        tick();
        bus.ram_ready = 1; bus.ram_rdata = 32'h77;
        #1;
        chk("ib_fill_iwait", {31'b0, bus.iwait}, 0);
        tick();
        bus.ram_ready = 0;
        #1;
        chk("ib_hit_iwait", {31'b0, bus.iwait}, 0);
        chk("ib_hit_iload", bus.iload, 32'h77);
        chk("ib_hit_req",   {31'b0, bus.ram_req}, 0);
        tick();
        #1;
        chk("ib_hit2_req", {31'b0, bus.ram_req}, 0);
        bus.iren = 0; bus.dwen = 4'hF; bus.daddr = 32'h10;
        tick();
        bus.ram_ready = 1;
        tick();
        idle_in();
        bus.iren = 1; bus.iaddr = 32'h10;
        #1;
        chk("ib_inv_iwait", {31'b0, bus.iwait}, 1);
        tick();
        #1;
        chk("ib_inv_req",  {31'b0, bus.ram_req}, 1);
        chk("ib_inv_addr", bus.ram_addr, 32'h10);
        tick();
        idle_in();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
